// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage register with an optional 2-entry skid buffer.
// Outputs always come from the main register; control is zeroed on every bubble.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // state   | meaning
  // S_EMPTY | no entry held
  // S_FULL  | entry in main register only
  // S_SKID  | main and skid registers both hold entries; input stalled
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              in_fire;
  logic              out_fire;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  always_ff @(posedge clk) begin
    if (rst || flush) state <= S_EMPTY;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (in_fire) state_nxt = S_FULL;
      S_FULL: begin
        if (in_fire && !out_fire)      state_nxt = S_SKID;
        else if (!in_fire && out_fire) state_nxt = S_EMPTY;
      end
      S_SKID:  if (out_fire) state_nxt = S_FULL;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state != S_EMPTY);
    in_fire   = in_valid && in_ready;
    out_fire  = (state != S_EMPTY) && out_ready;
  end

  // Registered in_ready cuts the combinational stall path back to the upstream stage.
  if (SKID != 0) begin : g_reg_ready
    logic in_ready_q;
    always_ff @(posedge clk) begin
      if (rst || flush) in_ready_q <= 1'b1;
      else              in_ready_q <= (state_nxt != S_SKID);
    end
    assign in_ready = in_ready_q;
  end else begin : g_comb_ready
    assign in_ready = (state == S_EMPTY) || out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_ctrl  <= '0;
      out_data  <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end
        end
        S_FULL: begin
          if (in_fire && out_fire) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end else if (in_fire) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (out_fire) begin
            // bubble: drop control so RegWrite/MemWrite cannot leak; payload holds
            out_ctrl <= '0;
          end
        end
        S_SKID: begin
          if (out_fire) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1/CNT_W=4 instance and a SKID=0 instance,
// each with a FIFO scoreboard plus per-scenario directed checks.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [10:0] in_ctrl_a, out_ctrl_a;
  logic [31:0] in_data_a, out_data_a;
  logic [3:0]  stall_a;

  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [10:0] in_ctrl_b, out_ctrl_b;
  logic [31:0] in_data_b, out_data_b;
  logic [15:0] stall_b;

  logic [42:0] q_a[$];
  logic [42:0] q_b[$];
  int          n_recv_b = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(11), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_ctrl(in_ctrl_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_ctrl(out_ctrl_a), .out_data(out_data_a),
    .stall_cnt(stall_a)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(11), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_ctrl(in_ctrl_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_ctrl(out_ctrl_b), .out_data(out_data_b),
    .stall_cnt(stall_b)
  );

  // scoreboards: push on in_fire, pop and compare on out_fire
  always @(negedge clk) begin
    logic [42:0] exp;
    if (rst || flush_a) begin
      q_a.delete();
    end else begin
      if (out_valid_a && out_ready_a) begin
        chk_cnt++;
        if (q_a.size() == 0) begin
          $display("FAIL sb_a_extra got %h_%h required no output", out_ctrl_a, out_data_a);
        end else begin
          exp = q_a.pop_front();
          if ({out_ctrl_a, out_data_a} !== exp)
            $display("FAIL sb_a_order got %h_%h required %h_%h", out_ctrl_a, out_data_a, exp[42:32], exp[31:0]);
          else pass_cnt++;
        end
      end
      if (in_valid_a && in_ready_a) q_a.push_back({in_ctrl_a, in_data_a});
    end
  end

  always @(negedge clk) begin
    logic [42:0] exp;
    if (rst || flush_b) begin
      q_b.delete();
    end else begin
      if (out_valid_b && out_ready_b) begin
        chk_cnt++;
        n_recv_b++;
        if (q_b.size() == 0) begin
          $display("FAIL sb_b_extra got %h_%h required no output", out_ctrl_b, out_data_b);
        end else begin
          exp = q_b.pop_front();
          if ({out_ctrl_b, out_data_b} !== exp)
            $display("FAIL sb_b_order got %h_%h required %h_%h", out_ctrl_b, out_data_b, exp[42:32], exp[31:0]);
          else pass_cnt++;
        end
      end
      if (in_valid_b && in_ready_b) q_b.push_back({in_ctrl_b, in_data_b});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk_cnt++;
    if ({out_valid_a, out_ctrl_a, out_data_a, stall_a, in_ready_a} !== {1'b0, 11'h0, 32'h0, 4'h0, 1'b1})
      $display("FAIL reset_a got v=%b c=%h d=%h s=%h r=%b required 0/0/0/0/1",
               out_valid_a, out_ctrl_a, out_data_a, stall_a, in_ready_a);
    else pass_cnt++;
    chk_cnt++;
    if ({out_valid_b, out_ctrl_b, out_data_b, stall_b, in_ready_b} !== {1'b0, 11'h0, 32'h0, 16'h0, 1'b1})
      $display("FAIL reset_b got v=%b c=%h d=%h s=%h r=%b required 0/0/0/0/1",
               out_valid_b, out_ctrl_b, out_data_b, stall_b, in_ready_b);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] d[3];
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
    out_ready_a = 1'b1;
    in_valid_a  = 1'b1; in_ctrl_a = 11'h1; in_data_a = d[0];
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if ({out_valid_a, in_ready_a, out_data_a} !== {2'b11, d[i]})
        $display("FAIL stream_%0d got v=%b r=%b d=%h required 1/1/%h", i, out_valid_a, in_ready_a, out_data_a, d[i]);
      else pass_cnt++;
      if (i < 2) begin
        in_ctrl_a = 11'(i + 2); in_data_a = d[i+1];
      end else begin
        in_valid_a = 1'b0;
      end
      cyc();
    end
    chk_cnt++;
    if ({out_valid_a, out_ctrl_a, out_data_a, stall_a} !== {1'b0, 11'h0, 32'h33, 4'h0})
      $display("FAIL stream_bubble got v=%b c=%h d=%h s=%h required 0/0/33/0", out_valid_a, out_ctrl_a, out_data_a, stall_a);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1; in_ctrl_a = 11'h2; in_data_a = 32'hA1;
    cyc();
    chk_cnt++;
    if ({out_valid_a, out_data_a, in_ready_a, stall_a} !== {1'b1, 32'hA1, 1'b1, 4'd0})
      $display("FAIL bp_load got v=%b d=%h r=%b s=%0d required 1/a1/1/0", out_valid_a, out_data_a, in_ready_a, stall_a);
    else pass_cnt++;
    in_ctrl_a = 11'h3; in_data_a = 32'hB2;
    cyc();
    chk_cnt++;
    if ({out_data_a, in_ready_a, stall_a} !== {32'hA1, 1'b0, 4'd1})
      $display("FAIL bp_skid got d=%h r=%b s=%0d required a1/0/1", out_data_a, in_ready_a, stall_a);
    else pass_cnt++;
    in_valid_a = 1'b0;
    cyc();
    chk_cnt++;
    if ({out_data_a, in_ready_a, stall_a} !== {32'hA1, 1'b0, 4'd2})
      $display("FAIL bp_hold got d=%h r=%b s=%0d required a1/0/2", out_data_a, in_ready_a, stall_a);
    else pass_cnt++;
    out_ready_a = 1'b1;
    cyc();
    chk_cnt++;
    if ({out_valid_a, out_ctrl_a, out_data_a, in_ready_a, stall_a} !== {1'b1, 11'h3, 32'hB2, 1'b1, 4'd2})
      $display("FAIL bp_release got v=%b c=%h d=%h r=%b s=%0d required 1/3/b2/1/2",
               out_valid_a, out_ctrl_a, out_data_a, in_ready_a, stall_a);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if ({out_valid_a, out_ctrl_a, out_data_a} !== {1'b0, 11'h0, 32'hB2})
      $display("FAIL bp_empty got v=%b c=%h d=%h required 0/0/b2", out_valid_a, out_ctrl_a, out_data_a);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1; in_ctrl_a = 11'h4; in_data_a = 32'hC1;
    cyc();
    in_ctrl_a = 11'h5; in_data_a = 32'hC2;
    cyc();
    in_ctrl_a = 11'h6; in_data_a = 32'hC3; flush_a = 1'b1;
    cyc();
    chk_cnt++;
    if ({out_valid_a, out_ctrl_a, out_data_a, in_ready_a} !== {1'b0, 11'h0, 32'h0, 1'b1})
      $display("FAIL flush got v=%b c=%h d=%h r=%b required 0/0/0/1", out_valid_a, out_ctrl_a, out_data_a, in_ready_a);
    else pass_cnt++;
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_cnt++;
      if (out_valid_a !== 1'b0)
        $display("FAIL flush_after_%0d got v=%b d=%h required v=0", i, out_valid_a, out_data_a);
      else pass_cnt++;
    end
  endtask

  task automatic test_drain();
    out_ready_a = 1'b1;
    in_valid_a  = 1'b1; in_ctrl_a = 11'h7FF; in_data_a = 32'hDEADBEEF;
    cyc();
    chk_cnt++;
    if ({out_valid_a, out_ctrl_a} !== {1'b1, 11'h7FF})
      $display("FAIL drain_full got v=%b c=%h required 1/7ff", out_valid_a, out_ctrl_a);
    else pass_cnt++;
    in_valid_a = 1'b0;
    cyc();
    chk_cnt++;
    if ({out_valid_a, out_ctrl_a, out_data_a} !== {1'b0, 11'h0, 32'hDEADBEEF})
      $display("FAIL drain_bubble got v=%b c=%h d=%h required 0/0/deadbeef", out_valid_a, out_ctrl_a, out_data_a);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_cnt++;
    if (stall_a !== 4'd0) $display("FAIL sat_rst0 got %0d required 0", stall_a);
    else pass_cnt++;
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1; in_ctrl_a = 11'h9; in_data_a = 32'hE5;
    cyc();
    in_valid_a = 1'b0;
    repeat (5) cyc();
    chk_cnt++;
    if (stall_a !== 4'd5) $display("FAIL sat_mid got %0d required 5", stall_a);
    else pass_cnt++;
    repeat (15) cyc();
    chk_cnt++;
    if ({stall_a, out_valid_a, out_data_a} !== {4'd15, 1'b1, 32'hE5})
      $display("FAIL sat_top got s=%0d v=%b d=%h required 15/1/e5", stall_a, out_valid_a, out_data_a);
    else pass_cnt++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_cnt++;
    if ({stall_a, out_valid_a} !== {4'd0, 1'b0})
      $display("FAIL sat_rst got s=%0d v=%b required 0/0", stall_a, out_valid_a);
    else pass_cnt++;
  endtask

  task automatic test_skid0();
    logic occ;
    logic exp_rdy;
    logic in_f;
    int   n_sent;
    logic [31:0] nxt;
    occ = 1'b0; n_sent = 0; nxt = 32'h100;
    for (int i = 0; i < 24; i++) begin
      out_ready_b = i[0];
      in_valid_b  = 1'b1; in_data_b = nxt; in_ctrl_b = nxt[10:0] ^ 11'h555;
      #1;
      exp_rdy = !occ || out_ready_b;
      chk_cnt++;
      if ({in_ready_b, out_valid_b} !== {exp_rdy, occ})
        $display("FAIL skid0_rdy_%0d got r=%b v=%b required r=%b v=%b", i, in_ready_b, out_valid_b, exp_rdy, occ);
      else pass_cnt++;
      in_f = exp_rdy;
      occ  = in_f || (occ && !out_ready_b);
      if (in_f) begin
        n_sent++;
        nxt = nxt + 32'h1;
      end
      cyc();
    end
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    repeat (3) cyc();
    chk_cnt++;
    if ((n_recv_b !== n_sent) || (q_b.size() != 0))
      $display("FAIL skid0_count got recv=%0d left=%0d required recv=%0d left=0", n_recv_b, q_b.size(), n_sent);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; in_valid_a = 1'b0; in_ctrl_a = '0; in_data_a = '0; out_ready_a = 1'b0;
    flush_b = 1'b0; in_valid_b = 1'b0; in_ctrl_b = '0; in_data_b = '0; out_ready_b = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_drain();
    test_saturate();
    test_skid0();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
